led_frame_buffer: RTL and testbench
===================================

// Module: led_frame_buffer
// PURPOSE
//  Double-buffered RGB444 frame store feeding the panel scan controller.
//  - Accepts a raster pixel stream (valid/ready) into the back page.
//  - Serves 1-cycle-latency reads of top-half (b1) and bottom-half (b2) pixels to the scan side.
//  - Swaps pages only on a scan frame-sync pulse, so the panel never shows a torn frame.
// PARAMETERS
//  COLS       48  pixels per row (scan side shifts this many per row)
//  HALF_ROWS  32  rows per half-panel; the panel is 2*HALF_ROWS rows tall
//  PIX_W      12  pixel width, {R[11:8],G[7:4],B[3:0]}
//  ADDR_W     12  scan-side read address width
// PORTS
//  i_clk           in   1       system clock
//  i_rst           in   1       synchronous reset, active-high
//  i_wr_valid      in   1       write pixel valid
//  o_wr_ready      out  1       write pixel ready
//  i_wr_data       in   PIX_W   pixel, raster order: row 0 col 0 first
//  i_wr_last       in   1       marks the final pixel of a frame
//  i_ram_addr      in   ADDR_W  scan read address = row*COLS + col
//  i_ram_read_stb  in   1       read enable
//  o_ram_b1_data   out  PIX_W   top-half pixel at i_ram_addr
//  o_ram_b2_data   out  PIX_W   bottom-half pixel at i_ram_addr
//  i_frame_sync    in   1       1-cycle pulse when the scan row wraps to 0
//  o_display_page  out  1       page currently read by the scan side
//  o_swap          out  1       1-cycle pulse on page swap
//  o_frame_err     out  1       1-cycle pulse when a malformed frame is dropped
// BEHAVIOUR
//  Clocking and reset
//  - One clock. Reset is synchronous and active-high.
//  - Reset values: o_wr_ready=1, o_ram_b*_data=0, o_display_page=0, o_swap=0, o_frame_err=0.
//  - Reset also clears: state=S_FILL, write row/col=0.
//  - RAM contents are not cleared by reset.
//  - Reset mid-frame discards the partial frame.
//  Storage
//  - Per half: 2 pages x 2^11 words x PIX_W; page bit is the address MSB.
//  - Only words 0..COLS*HALF_ROWS-1 (=1535) are used.
//  Write side
//  - Beat accepted when i_wr_valid && o_wr_ready.
//  - Position is tracked with col/row counters; no divider.
//  - col wraps at COLS-1, then row increments.
//  - Row < HALF_ROWS: write b1 RAM. Otherwise write b2 RAM at row-HALF_ROWS.
//  - Word address = {~o_display_page, r*COLS+c}.
//  FSM
//  - S_FILL, o_wr_ready=1:
//    - Accepted beat at row=2*HALF_ROWS-1, col=COLS-1 with i_wr_last=1: go to S_WAIT_SWAP.
//    - i_wr_last=1 at any other position: frame is malformed.
//    - Final-position pixel with i_wr_last=0: frame is malformed.
//    - On a malformed frame: pulse o_frame_err, reset row/col to 0, stay in S_FILL, no swap.
//    - The errored pixel is still written; this is harmless because it lands in the back page.
//  - S_WAIT_SWAP, o_wr_ready=0:
//    - On i_frame_sync: toggle o_display_page, pulse o_swap, reset row/col, go to S_FILL.
//  - i_frame_sync while in S_FILL is ignored.
//  - Sync in the same cycle as the completing beat does NOT swap; the next sync does.
//  - Swap timing is registered; o_display_page changes the cycle after the sync.
//  Read side
//  - Registered reads with 1-cycle latency.
//  - If i_ram_read_stb=1 in cycle N, o_ram_b1/b2_data reflect addr(N) from page o_display_page(N) in cycle N+1.
//  - If i_ram_read_stb=0, outputs hold their value.
//  - i_ram_addr >= COLS*HALF_ROWS returns 0 on both outputs.
//  - Only bits [10:0] index the RAM.
//  - Read and write never target the same page; no collision logic is needed.
// STRUCTURE
//  - Shared package holds COLS, HALF_ROWS, PIX_W, the FRAME_PIXELS constant and the state encoding.
//  - Sub-module led_fb_ram: simple dual-port RAM, 1 write port, 1 registered read port.
//  - Instantiate led_fb_ram twice (b1, b2); inference-friendly.
//  - Top level holds the FSM, counters, page bit and read-range gating.
// TESTING
//  1. Reset, then 3072 pixels of data = index[11:0] with last on the final one
//     -> o_wr_ready=0 after the final beat; o_display_page stays 0 until the sync pulse.
//  2. Pulse i_frame_sync after test 1 -> o_swap pulses once, o_display_page=1.
//     Then read addr 47 -> b1=0x02F and b2=0x62F one cycle later.
//  3. Send i_wr_last at pixel 100
//     -> o_frame_err pulses once; o_display_page is unchanged.
//     A following correct 3072-pixel frame completes normally.
//  4. Assert i_frame_sync in the same cycle as the last beat
//     -> no swap; swap occurs at the next sync.
//  5. Read addr 1536 with stb=1 -> outputs 0.
//     Deassert stb -> outputs hold their last value.
//  6. Assert i_rst mid-frame after 500 pixels
//     -> all outputs at reset values; a full frame then completes and swaps to page 1.

Source files
------------

// File: rtl/led_frame_buffer_pkg.sv
// rtl/led_frame_buffer_pkg.sv - shared geometry constants and FSM encoding for the LED frame buffer
package led_frame_buffer_pkg;

    localparam int COLS         = 48;
    localparam int HALF_ROWS    = 32;
    localparam int PIX_W        = 12;
    localparam int ADDR_W       = 12;
    localparam int HALF_WORDS   = COLS * HALF_ROWS;
    localparam int FRAME_PIXELS = 2 * HALF_WORDS;
    localparam int RAM_AW       = 11;
    localparam int ROW_W        = 6;
    localparam int COL_W        = 6;

    typedef enum logic [0:0] {
        S_FILL      = 1'b0,
        S_WAIT_SWAP = 1'b1
    } fb_state_t;

endpackage

// File: rtl/led_fb_ram.sv
// rtl/led_fb_ram.sv - simple dual-port RAM, one write port and one registered read port
module led_fb_ram #(
    parameter int DATA_W = 12,
    parameter int AW     = 12
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<AW)-1];

    // write port
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    // registered read port; data holds while the enable is low
    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            o_rd_data <= mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/led_frame_buffer.sv
// rtl/led_frame_buffer.sv - double-buffered RGB444 frame store with tear-free page swap
module led_frame_buffer
    import led_frame_buffer_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [PIX_W-1:0]  i_wr_data,
    input  logic              i_wr_last,
    input  logic [ADDR_W-1:0] i_ram_addr,
    input  logic              i_ram_read_stb,
    output logic [PIX_W-1:0]  o_ram_b1_data,
    output logic [PIX_W-1:0]  o_ram_b2_data,
    input  logic              i_frame_sync,
    output logic              o_display_page,
    output logic              o_swap,
    output logic              o_frame_err
);

    fb_state_t          state;
    fb_state_t          state_nxt;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic               wr_fire;
    logic               at_final;
    logic               frame_done;
    logic               frame_bad;
    logic               swap_now;
    logic [RAM_AW-1:0]  wr_word;
    logic [RAM_AW:0]    wr_addr;
    logic               b1_we;
    logic               b2_we;
    logic [RAM_AW:0]    rd_addr;
    logic               rd_in_range;
    logic               rd_valid;
    logic [PIX_W-1:0]   b1_q;
    logic [PIX_W-1:0]   b2_q;

    assign wr_fire    = i_wr_valid && o_wr_ready;
    assign at_final   = (row == ROW_W'(2*HALF_ROWS-1)) && (col == COL_W'(COLS-1));
    assign frame_done = wr_fire && at_final && i_wr_last;
    // last flag and final position must coincide, otherwise the frame is dropped
    assign frame_bad  = wr_fire && (at_final != i_wr_last);
    assign swap_now   = (state == S_WAIT_SWAP) && i_frame_sync;

    // the row MSB selects the half; the remaining row bits index within that half
    assign wr_word = RAM_AW'(row[ROW_W-2:0]) * RAM_AW'(COLS) + RAM_AW'(col);
    assign wr_addr = {~o_display_page, wr_word};
    assign b1_we   = wr_fire && !row[ROW_W-1];
    assign b2_we   = wr_fire &&  row[ROW_W-1];

    assign rd_addr     = {o_display_page, i_ram_addr[RAM_AW-1:0]};
    assign rd_in_range = i_ram_addr < ADDR_W'(HALF_WORDS);

    // state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and write-side handshake
    always_comb begin
        state_nxt  = state;
        o_wr_ready = 1'b0;
        case (state)
            S_FILL: begin
                o_wr_ready = 1'b1;
                if (frame_done) begin
                    state_nxt = S_WAIT_SWAP;
                end
            end
            S_WAIT_SWAP: begin
                if (i_frame_sync) begin
                    state_nxt = S_FILL;
                end
            end
            default: state_nxt = S_FILL;
        endcase
    end

    // raster position counters; any frame boundary (good, bad or swap) rewinds them
    always_ff @(posedge i_clk) begin
        if (i_rst || swap_now || frame_done || frame_bad) begin
            row <= '0;
            col <= '0;
        end else if (wr_fire) begin
            if (col == COL_W'(COLS-1)) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // page bit and status pulses
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_display_page <= 1'b0;
            o_swap         <= 1'b0;
            o_frame_err    <= 1'b0;
        end else begin
            o_swap      <= swap_now;
            o_frame_err <= frame_bad;
            if (swap_now) begin
                o_display_page <= ~o_display_page;
            end
        end
    end

    // out-of-range flag travels alongside the RAM read so gating lines up with the data
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_valid <= 1'b0;
        end else if (i_ram_read_stb) begin
            rd_valid <= rd_in_range;
        end
    end

    assign o_ram_b1_data = rd_valid ? b1_q : '0;
    assign o_ram_b2_data = rd_valid ? b2_q : '0;

    led_fb_ram #(.DATA_W(PIX_W), .AW(RAM_AW+1)) u_ram_b1 (
        .i_clk     (i_clk),
        .i_wr_en   (b1_we),
        .i_wr_addr (wr_addr),
        .i_wr_data (i_wr_data),
        .i_rd_en   (i_ram_read_stb),
        .i_rd_addr (rd_addr),
        .o_rd_data (b1_q)
    );

    led_fb_ram #(.DATA_W(PIX_W), .AW(RAM_AW+1)) u_ram_b2 (
        .i_clk     (i_clk),
        .i_wr_en   (b2_we),
        .i_wr_addr (wr_addr),
        .i_wr_data (i_wr_data),
        .i_rd_en   (i_ram_read_stb),
        .i_rd_addr (rd_addr),
        .o_rd_data (b2_q)
    );

endmodule

// File: tb/tb_led_frame_buffer.sv
// tb/tb_led_frame_buffer.sv - directed self-checking bench for led_frame_buffer
module tb_led_frame_buffer;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_wr_valid;
    logic        o_wr_ready;
    logic [11:0] i_wr_data;
    logic        i_wr_last;
    logic [11:0] i_ram_addr;
    logic        i_ram_read_stb;
    logic [11:0] o_ram_b1_data;
    logic [11:0] o_ram_b2_data;
    logic        i_frame_sync;
    logic        o_display_page;
    logic        o_swap;
    logic        o_frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int swap_cnt = 0;
    int err_cnt = 0;

    always #5 i_clk = ~i_clk;

    led_frame_buffer dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_wr_valid     (i_wr_valid),
        .o_wr_ready     (o_wr_ready),
        .i_wr_data      (i_wr_data),
        .i_wr_last      (i_wr_last),
        .i_ram_addr     (i_ram_addr),
        .i_ram_read_stb (i_ram_read_stb),
        .o_ram_b1_data  (o_ram_b1_data),
        .o_ram_b2_data  (o_ram_b2_data),
        .i_frame_sync   (i_frame_sync),
        .o_display_page (o_display_page),
        .o_swap         (o_swap),
        .o_frame_err    (o_frame_err)
    );

    // pulse counters sampled mid-cycle
    always @(negedge i_clk) begin
        if (o_swap)      swap_cnt++;
        if (o_frame_err) err_cnt++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_frame(input int n_pix, input int last_idx, input int xor_pat, input bit sync_on_last);
        for (int i = 0; i < n_pix; i++) begin
            i_wr_valid   = 1'b1;
            i_wr_data    = 12'(i) ^ 12'(xor_pat);
            i_wr_last    = (i == last_idx);
            i_frame_sync = sync_on_last && (i == n_pix - 1);
            tick();
        end
        i_wr_valid   = 1'b0;
        i_wr_last    = 1'b0;
        i_frame_sync = 1'b0;
    endtask

    task automatic pulse_sync();
        i_frame_sync = 1'b1;
        tick();
        i_frame_sync = 1'b0;
    endtask

    task automatic do_read(input int addr);
        i_ram_addr     = 12'(addr);
        i_ram_read_stb = 1'b1;
        tick();
        i_ram_read_stb = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; i_wr_valid = 1'b0; i_wr_data = '0; i_wr_last = 1'b0;
        i_ram_addr = '0; i_ram_read_stb = 1'b0; i_frame_sync = 1'b0;
        repeat (3) tick();

        // reset values
        check("rst_ready", o_wr_ready, 1);
        check("rst_b1", o_ram_b1_data, 0);
        check("rst_b2", o_ram_b2_data, 0);
        check("rst_page", o_display_page, 0);
        check("rst_swap", o_swap, 0);
        check("rst_err", o_frame_err, 0);
        i_rst = 1'b0;
        tick();

        // 1: full frame into page 1
        send_frame(3072, 3071, 0, 1'b0);
        check("t1_ready", o_wr_ready, 0);
        check("t1_page", o_display_page, 0);
        repeat (3) tick();
        check("t1_page_hold", o_display_page, 0);
        check("t1_no_swap", swap_cnt, 0);

        // 2: sync swaps, read back
        pulse_sync();
        check("t2_swap", o_swap, 1);
        check("t2_page", o_display_page, 1);
        tick();
        check("t2_swap_once", swap_cnt, 1);
        check("t2_ready", o_wr_ready, 1);
        do_read(47);
        check("t2_b1_47", o_ram_b1_data, 12'h02F);
        check("t2_b2_47", o_ram_b2_data, 12'h62F);
        do_read(1535);
        check("t2_b1_1535", o_ram_b1_data, 12'h5FF);
        check("t2_b2_1535", o_ram_b2_data, 12'hBFF);
        do_read(0);
        check("t2_b1_0", o_ram_b1_data, 0);
        check("t2_b2_0", o_ram_b2_data, 12'h600);

        // 5: hold with stb low, out-of-range reads
        do_read(47);
        i_ram_addr = 12'd200;
        tick();
        check("t5_hold_b1", o_ram_b1_data, 12'h02F);
        check("t5_hold_b2", o_ram_b2_data, 12'h62F);
        do_read(1536);
        check("t5_oor_b1", o_ram_b1_data, 0);
        check("t5_oor_b2", o_ram_b2_data, 0);
        i_ram_addr = 12'd47;
        tick();
        check("t5_oor_hold", o_ram_b1_data, 0);

        // 3: early last at pixel 100
        send_frame(101, 100, 0, 1'b0);
        check("t3_err", o_frame_err, 1);
        tick();
        check("t3_err_once", err_cnt, 1);
        check("t3_page", o_display_page, 1);
        check("t3_ready", o_wr_ready, 1);

        // sync in fill state is ignored
        pulse_sync();
        tick();
        check("t3_fill_sync", swap_cnt, 1);

        // 4: correct frame with sync on the last beat
        send_frame(3072, 3071, 12'hA5A, 1'b1);
        check("t4_ready", o_wr_ready, 0);
        check("t4_no_swap", o_swap, 0);
        repeat (2) tick();
        check("t4_swap_cnt", swap_cnt, 1);
        check("t4_no_err", err_cnt, 1);
        check("t4_page_hold", o_display_page, 1);
        pulse_sync();
        check("t4_page", o_display_page, 0);
        tick();
        check("t4_swap_cnt2", swap_cnt, 2);
        do_read(47);
        check("t4_b1_47", o_ram_b1_data, 12'hA75);
        check("t4_b2_47", o_ram_b2_data, 12'hC75);

        // 6: reset mid-frame
        send_frame(500, -1, 0, 1'b0);
        i_rst = 1'b1;
        tick();
        check("t6_ready", o_wr_ready, 1);
        check("t6_b1", o_ram_b1_data, 0);
        check("t6_b2", o_ram_b2_data, 0);
        check("t6_page", o_display_page, 0);
        check("t6_swap", o_swap, 0);
        check("t6_err", o_frame_err, 0);
        i_rst = 1'b0;
        tick();
        send_frame(3072, 3071, 0, 1'b0);
        check("t6_done", o_wr_ready, 0);
        check("t6_no_err", err_cnt, 1);
        pulse_sync();
        check("t6_page1", o_display_page, 1);
        tick();
        check("t6_swap_cnt", swap_cnt, 3);
        do_read(100);
        check("t6_b1_100", o_ram_b1_data, 12'h064);
        check("t6_b2_100", o_ram_b2_data, 12'h664);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
